data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Memory-side responder for the core's load/store port: accepts one load or
//  store request at a time, inserts programmable wait states, then performs the access.
//  Backing store is 64-bit doublewords. Reads and errors return on a registered
//  response channel. The core-side load/store unit is the initiator; this block
//  replaces the zero-latency data memory in multi-cycle and pipelined variants.
// PARAMETERS
//  DEPTH        64  number of 64-bit doublewords (power of 2, >=2)
//  WAIT_CYCLES  2   extra wait states per access (0..15)
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-low reset
//  req_valid  in   1   request present
//  req_ready  out  1   responder can accept request
//  req_write  in   1   1=store, 0=load
//  req_addr   in   64  byte address
//  req_wdata  in   64  store data
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   initiator accepts response
//  rsp_rdata  out  64  load data (0 for errors/write acks)
//  rsp_err    out  1   misaligned or out-of-range access
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0,
//   rsp_err=0, wait counter=0, all memory words cleared to 0. Deassertion sync to clk.
//  FSM states:
//   IDLE: req_ready=1. On req_valid&req_ready, register write/addr/wdata,
//    load cnt<=WAIT_CYCLES, go BUSY.
//   BUSY: req_ready=0. If cnt!=0: cnt<=cnt-1. If cnt==0: perform access, go RESP
//    (or IDLE, see CONFIGURATION).
//   RESP: rsp_valid=1; rsp_rdata/rsp_err held stable until rsp_valid&rsp_ready,
//    then go IDLE.
//  Latency: rsp_valid rises WAIT_CYCLES+1 clk edges after the accept edge.
//   The next request can be accepted 1 cycle after the response handshake.
//  Addressing: index = req_addr[3 +: log2(DEPTH)].
//   Error if req_addr[2:0]!=0, or if req_addr >= DEPTH*8 (any higher bit set).
//  Error access: no memory update. Response has rsp_err=1, rsp_rdata=0.
//   Error responses are always returned, including stores.
//  Load: rsp_rdata = mem[index], sampled on the perform edge.
//  Store: mem[index] <= wdata on the perform edge.
//  Request inputs are ignored outside the IDLE accept edge. Changes mid-access
//   have no effect.
//  reset asserted mid-access: the pending access is dropped. A store that has not
//   yet reached its perform edge does not update memory. Outputs return to reset values.
//  rsp_ready is ignored when rsp_valid=0.
// CONFIGURATION
//  DMEM_WRITE_ACK_EN defined: successful stores also go BUSY->RESP with
//   rsp_valid=1, rsp_rdata=0, rsp_err=0; one response per request.
//  Not defined: successful stores go BUSY->IDLE on the perform edge with no
//   response. Loads and errored stores still respond.
// TESTING
//  Store wdata=64'hDEAD_BEEF_0123_4567 to addr 0x10, then load 0x10 ->
//   rsp_rdata=64'hDEAD_BEEF_0123_4567, rsp_err=0.
//  WAIT_CYCLES=2, load accepted at edge N -> rsp_valid=1 after edge N+3.
//   WAIT_CYCLES=0 -> rsp_valid=1 after edge N+1.
//  Load 0x0C (misaligned) and 0x200 with DEPTH=64 (out of range) -> rsp_err=1,
//   rsp_rdata=0. Load 0x08 returns 0 (memory untouched by errored stores).
//  Hold rsp_ready=0 for 5 cycles during a load -> rsp_valid/rsp_rdata stable,
//   req_ready=0. A second req_valid is not accepted until 1 cycle after the handshake.
//  Assert reset mid-BUSY of store 64'h1 to 0x18 -> outputs reset; later load
//   of 0x18 -> 0.
//  Store with DMEM_WRITE_ACK_EN -> one rsp_valid pulse, rsp_err=0.
//   Without the macro -> no rsp_valid, req_ready=1 after WAIT_CYCLES+1 edges.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder for the core load/store port. It accepts one request
//   at a time, waits WAIT_CYCLES extra cycles, then performs the access against
//   a DEPTH x 64-bit doubleword store. Loads and errors answer on a registered
//   response channel.
//
//   Optional feature macro: DMEM_WRITE_ACK_EN
//     defined     - successful stores also return a response (rdata=0, err=0)
//     not defined - successful stores retire silently on the perform edge
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both 1. The initiator holds req_* stable while req_valid is high and not
//   yet accepted. The responder holds rsp_rdata/rsp_err stable while rsp_valid
//   is high and rsp_ready is low. Ready never depends combinationally on valid.
//
//   dbg_state exposes the FSM state (0=IDLE, 1=BUSY, 2=RESP).
module data_mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [63:0]   addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [63:0]   mem_q [DEPTH];

  logic          mem_we;
  logic [AW-1:0] idx;
  logic          addr_err;

  // Doubleword index and error decode of the captured request address.
  always_comb begin
    idx      = addr_q[3 +: AW];
    addr_err = (addr_q[2:0] != 3'b000) || ((addr_q >> (3 + AW)) != 64'd0);
  end

  // Next-state logic: accept in IDLE, count wait states in BUSY, then perform.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = WAIT_LOAD;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (addr_err) begin
          // Errors always respond, stores included, and never touch memory.
          rdata_d = 64'd0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (wr_q) begin
          mem_we  = 1'b1;
          rdata_d = 64'd0;
          err_d   = 1'b0;
`ifdef DMEM_WRITE_ACK_EN
          state_d = S_RESP;
`else
          state_d = S_IDLE;
`endif
        end else begin
          rdata_d = mem_q[idx];
          err_d   = 1'b0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rdata_d = 64'd0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Backing store; reset clears every word so a dropped store leaves no trace.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 64'd0;
      end
    end else if (mem_we) begin
      mem_q[idx] <= wdata_q;
    end
  end

  // Output mapping.
  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Directed bench: a vector table of single requests with hand-computed
//   results, then hand-written sequences for backpressure, mid-access reset
//   and zero-wait-state latency.
module tb_data_mem_responder;

  localparam int WAIT = 2;
`ifdef DMEM_WRITE_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  localparam logic [63:0] V_BEEF = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] V_TOP  = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] V_AAAA = 64'hAAAA_5555_AAAA_5555;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- DUT (WAIT_CYCLES=2) ----------------
  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [63:0] req_addr = 64'd0, req_wdata = 64'd0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;
  logic [1:0]  dbg_state;

  data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(WAIT)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  // ---------------- DUT (WAIT_CYCLES=0) ----------------
  logic        req_valid0 = 1'b0, req_write0 = 1'b0, rsp_ready0 = 1'b0;
  logic [63:0] req_addr0 = 64'd0, req_wdata0 = 64'd0;
  logic        req_ready0, rsp_valid0, rsp_err0;
  logic [63:0] rsp_rdata0;
  logic [1:0]  dbg_state0;

  data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
    .req_addr(req_addr0), .req_wdata(req_wdata0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0), .dbg_state(dbg_state0)
  );

  // ---------------- scoreboard ----------------
  int pass_cnt = 0;
  int total_cnt = 0;
  logic [64:0] exp_q[$];   // {err, rdata}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // ---------------- driver tasks (called at posedge+#1) ----------------
  task automatic send_req(input logic wr, input logic [63:0] a, input logic [63:0] d);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) check("req_ready_timeout", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    // Scramble request inputs mid-access; the DUT must ignore them.
    req_valid = 1'b0; req_write = ~wr;
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
  endtask

  // Wait for either a response or a return to IDLE; returns edges counted.
  task automatic wait_done(output int k);
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (!rsp_valid && !req_ready && k < 40);
    if (!rsp_valid && !req_ready) check("done_timeout", 64'(k), 64'(WAIT + 1));
  endtask

  task automatic take_rsp(input string tag);
    logic [64:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected_rsp"}, 64'(rsp_valid), 64'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_rdata"}, rsp_rdata, e[63:0]);
      check({tag, "_err"}, 64'(rsp_err), 64'(e[64]));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_rsp_valid_after_hs"}, 64'(rsp_valid), 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        exp_rsp;
    logic        exp_err;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs[13];

  task automatic run_vec(input int i);
    int k;
    string tag;
    tag = $sformatf("v%0d", i);
    send_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
    if (vecs[i].exp_rsp) exp_q.push_back({vecs[i].exp_err, vecs[i].exp_rdata});
    wait_done(k);
    check({tag, "_latency"}, 64'(k), 64'(WAIT + 1));
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(vecs[i].exp_rsp));
    if (rsp_valid) take_rsp(tag);
    if (exp_q.size() != 0) begin
      check({tag, "_missing_rsp"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    check({tag, "_req_ready_idle"}, 64'(req_ready), 64'd1);
  endtask

  // ---------------- main test ----------------
  initial begin
    int k;
    vecs[0]  = '{1'b1, 64'h10,  V_BEEF,     ACK_EN, 1'b0, 64'd0};
    vecs[1]  = '{1'b0, 64'h10,  64'd0,      1'b1,   1'b0, V_BEEF};
    vecs[2]  = '{1'b1, 64'h0C,  64'hFFFF,   1'b1,   1'b1, 64'd0};
    vecs[3]  = '{1'b1, 64'h200, 64'hFFFF,   1'b1,   1'b1, 64'd0};
    vecs[4]  = '{1'b0, 64'h0C,  64'd0,      1'b1,   1'b1, 64'd0};
    vecs[5]  = '{1'b0, 64'h200, 64'd0,      1'b1,   1'b1, 64'd0};
    vecs[6]  = '{1'b0, 64'h08,  64'd0,      1'b1,   1'b0, 64'd0};
    vecs[7]  = '{1'b1, 64'h1F8, V_TOP,      ACK_EN, 1'b0, 64'd0};
    vecs[8]  = '{1'b0, 64'h1F8, 64'd0,      1'b1,   1'b0, V_TOP};
    vecs[9]  = '{1'b0, 64'h00,  64'd0,      1'b1,   1'b0, 64'd0};
    vecs[10] = '{1'b0, 64'h8000_0000_0000_0000, 64'd0, 1'b1, 1'b1, 64'd0};
    vecs[11] = '{1'b1, 64'h08,  V_AAAA,     ACK_EN, 1'b0, 64'd0};
    vecs[12] = '{1'b0, 64'h08,  64'd0,      1'b1,   1'b0, V_AAAA};

    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    check("rst_rsp_err",   64'(rsp_err), 64'd0);
    check("rst_state",     64'(dbg_state), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) run_vec(i);

    // Backpressure: response held for 5 cycles while a second request waits.
    send_req(1'b0, 64'h08, 64'd0);
    exp_q.push_back({1'b0, V_AAAA});
    wait_done(k);
    check("bp_latency", 64'(k), 64'(WAIT + 1));
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h1F8; req_wdata = 64'd0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_valid", c), 64'(rsp_valid), 64'd1);
      check($sformatf("bp_hold%0d_rdata", c), rsp_rdata, V_AAAA);
      check($sformatf("bp_hold%0d_ready", c), 64'(req_ready), 64'd0);
    end
    take_rsp("bp");
    check("bp_ready_after_hs", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp_second_accepted", 64'(dbg_state), 64'd1);
    exp_q.push_back({1'b0, V_TOP});
    wait_done(k);
    check("bp_second_latency", 64'(k), 64'(WAIT + 1));
    if (rsp_valid) take_rsp("bp_second");
    else check("bp_second_rsp", 64'(rsp_valid), 64'd1);
    exp_q.delete();

    // Reset in the middle of a store's wait states.
    send_req(1'b1, 64'h18, 64'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_rsp_rdata", rsp_rdata, 64'd0);
    check("midrst_rsp_err",   64'(rsp_err), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    send_req(1'b0, 64'h18, 64'd0);
    exp_q.push_back({1'b0, 64'd0});
    wait_done(k);
    if (rsp_valid) take_rsp("midrst_load18");
    else check("midrst_load18_rsp", 64'(rsp_valid), 64'd1);
    exp_q.delete();

    // Zero wait states: response one edge after accept.
    req_valid0 = 1'b1; req_write0 = 1'b0; req_addr0 = 64'h10;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    check("w0_load_busy", 64'(rsp_valid0), 64'd0);
    @(posedge clk); #1;
    check("w0_load_valid", 64'(rsp_valid0), 64'd1);
    check("w0_load_rdata", rsp_rdata0, 64'd0);
    rsp_ready0 = 1'b1;
    @(posedge clk); #1;
    rsp_ready0 = 1'b0;
    req_valid0 = 1'b1; req_write0 = 1'b1; req_addr0 = 64'h10; req_wdata0 = 64'h5A5A;
    @(posedge clk); #1;
    req_valid0 = 1'b0; req_wdata0 = 64'h0;
    @(posedge clk); #1;
    check("w0_store_rsp_valid", 64'(rsp_valid0), 64'(ACK_EN));
    check("w0_store_req_ready", 64'(req_ready0), 64'(!ACK_EN));
    if (rsp_valid0) begin
      check("w0_store_err", 64'(rsp_err0), 64'd0);
      rsp_ready0 = 1'b1;
      @(posedge clk); #1;
      rsp_ready0 = 1'b0;
    end
    req_valid0 = 1'b1; req_write0 = 1'b0; req_addr0 = 64'h10;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    @(posedge clk); #1;
    check("w0_reload_valid", 64'(rsp_valid0), 64'd1);
    check("w0_reload_rdata", rsp_rdata0, 64'h5A5A);
    rsp_ready0 = 1'b1;
    @(posedge clk); #1;
    rsp_ready0 = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
